// File: rtl/busmux_rr_arbiter_pkg.sv
// rtl/busmux_rr_arbiter_pkg.sv - shared FSM state codes and width helper for the bus arbiter
package busmux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/busmux_rr_arbiter_pick.sv
// rtl/busmux_rr_arbiter_pick.sv - combinational round-robin winner search starting at ptr
module busmux_rr_arbiter_pick
    import busmux_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [PTRW-1:0] grant,
    output logic            valid
);

    // Scan from ptr upward, wrapping NREQ-1 -> 0; first set bit wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = PTRW'(idx);
            end
        end
    end

endmodule

// File: rtl/busmux_rr_arbiter.sv
// rtl/busmux_rr_arbiter.sv - round-robin arbiter serialising NREQ requesters onto one register-bank bus
module busmux_rr_arbiter
    import busmux_rr_arbiter_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int NREQ  = 3,
    parameter int ADDRW = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_we,
    input  logic [NREQ*ADDRW-1:0] i_addr,
    input  logic [NREQ*DATAW-1:0] i_wdata,
    output logic [NREQ-1:0]    o_ack,
    output logic [DATAW-1:0]   o_rdata,
    output logic               o_busy,
    output logic               o_bus_we,
    output logic [ADDRW-1:0]   o_bus_addr,
    output logic [DATAW-1:0]   o_bus_wdata,
    input  logic [DATAW-1:0]   i_bus_rdata
);

    localparam int PTRW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

    state_t            state;
    logic [PTRW-1:0]   ptr;
    logic [PTRW-1:0]   winner;
    logic [PTRW-1:0]   pick_grant;
    logic              pick_valid;
    logic [PTRW-1:0]   next_ptr;
    logic [ADDRW-1:0]  sel_addr;
    logic [DATAW-1:0]  sel_wdata;
    logic              sel_we;

    busmux_rr_arbiter_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_grant == PTRW'(k)) begin
                sel_addr  = i_addr[k*ADDRW +: ADDRW];
                sel_wdata = i_wdata[k*DATAW +: DATAW];
                sel_we    = i_we[k];
            end
        end
    end

    assign next_ptr = (pick_grant == PTRW'(NREQ - 1)) ? '0 : pick_grant + 1'b1;

    // Payload is captured only on the IDLE grant edge and held through DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            winner      <= '0;
            o_ack       <= '0;
            o_rdata     <= '0;
            o_busy      <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        winner      <= pick_grant;
                        ptr         <= next_ptr;
                        o_bus_addr  <= sel_addr;
                        o_bus_wdata <= sel_wdata;
                        o_bus_we    <= sel_we;
                        o_busy      <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_bus_we <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    o_rdata <= i_bus_rdata;
                    o_ack   <= NREQ'(1) << winner;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    o_ack  <= '0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_busmux_rr_arbiter.sv
// tb/tb_busmux_rr_arbiter.sv - directed self-checking bench for busmux_rr_arbiter
module tb_busmux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [2:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:255];
    logic       bank_init;

    always #5 clk = ~clk;

    busmux_rr_arbiter #(
        .DATAW (8),
        .NREQ  (3),
        .ADDRW (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_ack       (ack),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .i_bus_rdata (bus_rdata)
    );

    // Register bank: registered read, returns pre-write content on a write edge.
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[2]    <= 8'h11;
            bus_rdata <= 8'h00;
        end else begin
            bus_rdata <= mem[bus_addr];
            if (bus_we) mem[bus_addr] <= bus_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_access(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                              input logic mutate,
                              output logic [2:0] got_ack, output logic [7:0] got_rdata,
                              output int lat, output int we_cyc,
                              output logic [7:0] seen_addr, output logic [7:0] seen_wdata,
                              output logic stable, output logic [2:0] ack_after);
        req = 3'b000;
        we[k] = w;
        addr[k*8 +: 8]  = a;
        wdata[k*8 +: 8] = d;
        req[k] = 1'b1;
        lat = 0; we_cyc = 0; got_ack = 3'b000; got_rdata = 8'h00;
        seen_addr = 8'h00; seen_wdata = 8'h00; stable = 1'b1;
        while (lat < 20 && got_ack == 3'b000) begin
            @(negedge clk);
            lat++;
            if (mutate && lat == 1) begin
                addr[k*8 +: 8]  = ~a;
                wdata[k*8 +: 8] = ~d;
            end
            if (bus_we) begin
                we_cyc++;
                seen_addr  = bus_addr;
                seen_wdata = bus_wdata;
            end
            if (busy && bus_addr !== a) stable = 1'b0;
            if (ack != 3'b000) begin
                got_ack   = ack;
                got_rdata = rdata;
            end
        end
        req[k] = 1'b0;
        @(negedge clk);
        ack_after = ack;
    endtask

    logic [2:0] r_ack, r_after;
    logic [7:0] r_rdata, r_addr, r_wdata;
    logic       r_stable;
    int         r_lat, r_we;
    logic [2:0] order [0:2];
    int         at [0:2];
    logic [7:0] rd [0:2];
    int         n_ack;
    int         cyc;

    initial begin
        rst_n = 1'b0; bank_init = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ack",   {29'd0, ack}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_we",    {31'd0, bus_we}, 32'd0);
        check("rst_addr",  {24'd0, bus_addr}, 32'd0);
        check("rst_wdata", {24'd0, bus_wdata}, 32'd0);
        bank_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 1: requester 0 writes 0xA5 to 0x01
        run_access(0, 1'b1, 8'h01, 8'hA5, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t1_ack", {29'd0, r_ack}, 32'h1);
        check("t1_lat", r_lat, 32'd3);
        check("t1_we_cycles", r_we, 32'd1);
        check("t1_bus_addr", {24'd0, r_addr}, 32'h01);
        check("t1_bus_wdata", {24'd0, r_wdata}, 32'hA5);
        check("t1_ack_one_cycle", {29'd0, r_after}, 32'd0);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);

        // 2: requester 1 reads 0x01
        run_access(1, 1'b0, 8'h01, 8'h00, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t2_ack", {29'd0, r_ack}, 32'h2);
        check("t2_lat", r_lat, 32'd3);
        check("t2_rdata", {24'd0, r_rdata}, 32'hA5);
        check("t2_we_cycles", r_we, 32'd0);

        // requester 2 read of 0x00 brings pointer back to 0
        run_access(2, 1'b0, 8'h00, 8'h00, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t3_pre_ack", {29'd0, r_ack}, 32'h4);
        check("t3_pre_rdata", {24'd0, r_rdata}, 32'h00);

        // 3: all three together from pointer 0, reading 0x00/0x01/0x02
        we = 3'b000;
        addr = {8'h02, 8'h01, 8'h00};
        req = 3'b111;
        n_ack = 0; cyc = 0;
        while (n_ack < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack != 3'b000) begin
                order[n_ack] = ack; at[n_ack] = cyc; rd[n_ack] = rdata;
                n_ack++;
                req = req & ~ack;
            end
        end
        req = 3'b000;
        check("t3_n_acks", n_ack, 32'd3);
        check("t3_order0", {29'd0, order[0]}, 32'h1);
        check("t3_order1", {29'd0, order[1]}, 32'h2);
        check("t3_order2", {29'd0, order[2]}, 32'h4);
        check("t3_at0", at[0], 32'd3);
        check("t3_at1", at[1], 32'd7);
        check("t3_at2", at[2], 32'd11);
        check("t3_rd0", {24'd0, rd[0]}, 32'h00);
        check("t3_rd1", {24'd0, rd[1]}, 32'hA5);
        check("t3_rd2", {24'd0, rd[2]}, 32'h11);
        @(negedge clk);
        run_access(2, 1'b0, 8'h01, 8'h00, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t3_req2_alone_ack", {29'd0, r_ack}, 32'h4);
        check("t3_req2_alone_lat", r_lat, 32'd3);

        // pointer back at 0: requesters 1 and 2 together -> 1 first
        req = 3'b110;
        n_ack = 0; cyc = 0;
        while (n_ack < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ack != 3'b000) begin
                order[n_ack] = ack; n_ack++;
                req = req & ~ack;
            end
        end
        req = 3'b000;
        check("t3_ptr_wrap_first", {29'd0, order[0]}, 32'h2);
        check("t3_ptr_wrap_second", {29'd0, order[1]}, 32'h4);
        @(negedge clk);

        // 4: write 0x3C over 0x11 at 0x02, then read back
        run_access(0, 1'b1, 8'h02, 8'h3C, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t4_wr_ack", {29'd0, r_ack}, 32'h1);
        check("t4_wr_old", {24'd0, r_rdata}, 32'h11);
        run_access(1, 1'b0, 8'h02, 8'h00, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t4_rd_new", {24'd0, r_rdata}, 32'h3C);

        // 5: reset during WAIT
        we = 3'b000;
        addr[7:0] = 8'h01;
        req = 3'b001;
        @(negedge clk);
        check("t5_issue_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        req = 3'b000;
        #1;
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        check("t5_async_we", {31'd0, bus_we}, 32'd0);
        check("t5_async_ack", {29'd0, ack}, 32'd0);
        r_after = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_after = r_after | ack;
        end
        check("t5_no_ack", {29'd0, r_after}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        addr = {8'h00, 8'h01, 8'h01};
        req = 3'b011;
        n_ack = 0; cyc = 0;
        while (n_ack < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ack != 3'b000) begin
                order[n_ack] = ack; at[n_ack] = cyc; rd[n_ack] = rdata; n_ack++;
                req = req & ~ack;
            end
        end
        req = 3'b000;
        check("t5_post_first", {29'd0, order[0]}, 32'h1);
        check("t5_post_lat", at[0], 32'd3);
        check("t5_post_rdata", {24'd0, rd[0]}, 32'hA5);
        check("t5_post_second", {29'd0, order[1]}, 32'h2);
        @(negedge clk);

        // 6: requester 2 changes payload after sampling
        run_access(2, 1'b1, 8'h05, 8'h77, 1'b1, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t6_ack", {29'd0, r_ack}, 32'h4);
        check("t6_addr_stable", {31'd0, r_stable}, 32'd1);
        check("t6_bus_addr", {24'd0, r_addr}, 32'h05);
        check("t6_bus_wdata", {24'd0, r_wdata}, 32'h77);
        run_access(0, 1'b0, 8'h05, 8'h00, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t6_rd5", {24'd0, r_rdata}, 32'h77);
        run_access(1, 1'b0, 8'hFA, 8'h00, 1'b0, r_ack, r_rdata, r_lat, r_we, r_addr, r_wdata, r_stable, r_after);
        check("t6_rd_mutated_addr", {24'd0, r_rdata}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
